// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared definitions for the Digital_II arithmetic set.
// Holds the divider FSM encoding and the width helpers that the divider
// and the combinational multiplier both derive their port widths from.
package seq_divider_pkg;

  // Divider control states: waiting, shifting one bit per clock, publishing.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // DW: double width, i.e. the multiplier product / divider dividend width.
  function automatic int dw_of(input int nBits);
    return 2 * nBits;
  endfunction

  // CW: bit counter width, wide enough to hold every value 0 .. DW.
  function automatic int cw_of(input int nBits);
    return $clog2(2 * nBits + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, then subtracts
// the divisor when it fits and reports the resulting quotient bit.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic [N_BITS:0]   partialRem_i,
  input  logic              bit_i,
  input  logic [N_BITS-1:0] divisor_i,
  output logic [N_BITS:0]   partialRem_o,
  output logic              qBit_o
);

  logic [N_BITS:0] remTmp;
  logic [N_BITS:0] divisorExt;
  logic            overflow;
  logic            fits;

  // Trial subtraction. The partial remainder always stays below the divisor,
  // so its top bit is normally 0; if it were ever set, the shifted value would
  // already exceed any N_BITS divisor, so it is treated as "fits" outright.
  always_comb begin
    remTmp       = {partialRem_i[N_BITS-1:0], bit_i};
    divisorExt   = {1'b0, divisor_i};
    overflow     = partialRem_i[N_BITS];
    fits         = overflow | (remTmp >= divisorExt);
    qBit_o       = fits;
    partialRem_o = remTmp;
    if (fits) begin
      partialRem_o = remTmp - divisorExt;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, the inverse of the N_BITS x
// N_BITS multiplier. Divides a 2*N_BITS dividend by an N_BITS divisor, one
// quotient bit per clock, behind a start/busy/done handshake. Results live in
// their own output registers and only change on the done cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*N_BITS-1:0]     dividend,
  input  logic [N_BITS-1:0]       divisor,
  output logic [2*N_BITS-1:0]     quotient,
  output logic [N_BITS-1:0]       remainder,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int DW = dw_of(N_BITS);
  localparam int CW = cw_of(N_BITS);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  // Control state
  state_t state_q, state_d;
  logic [CW-1:0] stepCnt_q, stepCnt_d;

  // Working registers for the operation in flight
  logic [DW-1:0]     dividendShift_q, dividendShift_d;
  logic [N_BITS-1:0] divisor_q, divisor_d;
  logic [N_BITS:0]   partialRem_q, partialRem_d;
  logic [DW-1:0]     workQuot_q, workQuot_d;

  // Published results
  logic [DW-1:0]     quotient_q, quotient_d;
  logic [N_BITS-1:0] remainder_q, remainder_d;
  logic              divByZero_q, divByZero_d;
  logic              done_q, done_d;

  // Datapath for the current step
  logic [N_BITS:0] stepRem;
  logic            stepQBit;

  seq_divider_div_step #(
    .N_BITS (N_BITS)
  ) uStep (
    .partialRem_i (partialRem_q),
    .bit_i        (dividendShift_q[DW-1]),
    .divisor_i    (divisor_q),
    .partialRem_o (stepRem),
    .qBit_o       (stepQBit)
  );

  // State and datapath registers; reset aborts any operation without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      stepCnt_q       <= '0;
      dividendShift_q <= '0;
      divisor_q       <= '0;
      partialRem_q    <= '0;
      workQuot_q      <= '0;
      quotient_q      <= '0;
      remainder_q     <= '0;
      divByZero_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      stepCnt_q       <= stepCnt_d;
      dividendShift_q <= dividendShift_d;
      divisor_q       <= divisor_d;
      partialRem_q    <= partialRem_d;
      workQuot_q      <= workQuot_d;
      quotient_q      <= quotient_d;
      remainder_q     <= remainder_d;
      divByZero_q     <= divByZero_d;
      done_q          <= done_d;
    end
  end

  // Next-state and datapath control: capture in IDLE, shift in RUN, publish in FINISH.
  always_comb begin
    state_d         = state_q;
    stepCnt_d       = stepCnt_q;
    dividendShift_d = dividendShift_q;
    divisor_d       = divisor_q;
    partialRem_d    = partialRem_q;
    workQuot_d      = workQuot_q;
    quotient_d      = quotient_q;
    remainder_d     = remainder_q;
    divByZero_d     = divByZero_q;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dividendShift_d = dividend;
          divisor_d       = divisor;
          partialRem_d    = '0;
          workQuot_d      = '0;
          stepCnt_d       = '0;
          if (divisor == '0) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        partialRem_d    = stepRem;
        workQuot_d      = {workQuot_q[DW-2:0], stepQBit};
        dividendShift_d = {dividendShift_q[DW-2:0], 1'b0};
        stepCnt_d       = stepCnt_q + 1'b1;
        if (stepCnt_q == LAST_STEP) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = dividendShift_q[N_BITS-1:0];
          divByZero_d = 1'b1;
        end else begin
          quotient_d  = workQuot_q;
          remainder_d = partialRem_q[N_BITS-1:0];
          divByZero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (N_BITS = 4).
// Expected results come from plain integer division and the divide-by-zero
// rule; handshake timing is checked against the stated cycle counts.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] prevQ = 8'd0;

  seq_divider #(
    .N_BITS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, passes or reports tag/observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Issues one start, optionally pokes start with other operands mid-run,
  // and reports done latency, busy length, done width and mid-run quotient.
  task automatic applyStimulus(input logic [7:0] dd, input logic [3:0] ds, input int pokeAt,
                               output int doneEdge, output int busyCycles,
                               output logic doneAfter, output logic [7:0] qMid);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) checkOutput("idle_wait", busy, 0);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    busyCycles = (busy === 1'b1) ? 1 : 0;
    doneEdge   = -1;
    qMid       = quotient;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == pokeAt) begin
        start    = 1'b1;
        dividend = ~dd;
        divisor  = ds + 4'd1;
      end else if (k == pokeAt + 1) begin
        start = 1'b0;
      end
      if (k == 4) qMid = quotient;
      if (done === 1'b1) begin
        doneEdge = k;
        break;
      end
      if (busy === 1'b1) busyCycles++;
    end
    start = 1'b0;
    if (doneEdge > 0) begin
      @(posedge clk);
      #1;
      doneAfter = done;
    end else begin
      doneAfter = 1'b1;
    end
  endtask

  // Runs one division and compares against integer division / zero rule
  task automatic runCase(input string tag, input logic [7:0] dd, input logic [3:0] ds, input int pokeAt);
    int         doneEdge, busyCycles;
    logic       doneAfter;
    logic [7:0] qMid;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         eLat;
    if (ds == 4'd0) begin
      eq = 8'hFF; er = dd[3:0]; ez = 1'b1; eLat = 1;
    end else begin
      eq = 8'(int'(dd) / int'(ds));
      er = 4'(int'(dd) % int'(ds));
      ez = 1'b0; eLat = 9;
    end
    applyStimulus(dd, ds, pokeAt, doneEdge, busyCycles, doneAfter, qMid);
    checkOutput({tag, " latency"}, doneEdge, eLat);
    checkOutput({tag, " busy_len"}, busyCycles, eLat);
    checkOutput({tag, " quotient"}, quotient, eq);
    checkOutput({tag, " remainder"}, remainder, er);
    checkOutput({tag, " dbz"}, div_by_zero, ez);
    checkOutput({tag, " done_width"}, doneAfter, 0);
    checkOutput({tag, " hold_in_run"}, qMid, prevQ);
    prevQ = eq;
  endtask

  logic [7:0] vecDd [9] = '{8'd40, 8'd72, 8'd225, 8'd132, 8'd133, 8'd255, 8'd0, 8'd14, 8'd255};
  logic [3:0] vecDs [9] = '{4'd5, 4'd12, 4'd15, 4'd11, 4'd11, 4'd1, 4'd7, 4'd15, 4'd15};

  initial begin
    logic       sawDone;
    logic       prevDone;
    int         pulses, lastDone;
    logic       intervalOk, widthOk, idleOk, resultOk;
    logic [7:0] rdd;
    logic [3:0] rds;

    // Reset state
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #25;
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Multiplier inverses, nonzero remainders and extremes
    for (int i = 0; i < 9; i++) runCase($sformatf("vec%0d", i), vecDd[i], vecDs[i], 0);

    // Divide by zero, then a normal op clears the flag
    runCase("div0 200/0", 8'd200, 4'd0, 0);
    runCase("after_div0 10/3", 8'd10, 4'd3, 0);

    // Start pulsed mid-run with other operands is ignored
    runCase("poke 100/7", 8'd100, 4'd7, 3);

    // Reset in the middle of a run, with nonzero results showing beforehand
    runCase("div0 again", 8'd200, 4'd0, 0);
    @(negedge clk);
    dividend = 8'd40; divisor = 4'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset quotient", quotient, 0);
    checkOutput("midreset remainder", remainder, 0);
    checkOutput("midreset dbz", div_by_zero, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("midreset no_done", sawDone, 0);
    prevQ = 8'd0;
    runCase("post_reset 40/5", 8'd40, 4'd5, 0);

    // start held high: back-to-back ops, one idle cycle between, single-cycle done
    @(negedge clk);
    dividend = 8'd50; divisor = 4'd7; start = 1'b1;
    pulses = 0; lastDone = -1; prevDone = 1'b0;
    intervalOk = 1'b1; widthOk = 1'b1; idleOk = 1'b1; resultOk = 1'b1;
    for (int k = 0; k < 42; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (prevDone) widthOk = 1'b0;
        if (busy !== 1'b0) idleOk = 1'b0;
        if (quotient !== 8'd7 || remainder !== 4'd1) resultOk = 1'b0;
        if (lastDone >= 0 && (k - lastDone) != 10) intervalOk = 1'b0;
        if (lastDone < 0 && k != 9) intervalOk = 1'b0;
        lastDone = k;
        pulses++;
      end
      prevDone = (done === 1'b1);
    end
    start = 1'b0;
    checkOutput("held pulses", pulses, 4);
    checkOutput("held interval", intervalOk, 1);
    checkOutput("held done_width", widthOk, 1);
    checkOutput("held idle_gap", idleOk, 1);
    checkOutput("held result", resultOk, 1);
    for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);
    checkOutput("held drain", busy, 0);
    prevQ = 8'd7;

    // Random operands with nonzero divisor: model plus the division invariant
    for (int i = 0; i < 500; i++) begin
      rdd = 8'($urandom_range(0, 255));
      rds = 4'($urandom_range(1, 15));
      runCase($sformatf("rand%0d %0d/%0d", i, rdd, rds), rdd, rds, 0);
      checkOutput("rand invariant", int'(quotient) * int'(rds) + int'(remainder), int'(rdd));
      checkOutput("rand rem_lt_div", (remainder < rds), 1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
